// File: rtl/rv_iommu.sv
// Shared IOMMU HPM types: event configuration register layout, event queue entry,
// eventid constants and the event matching rules used by the event counters.
package rv_iommu;

  localparam logic [14:0] UT_REQ     = 15'd1;
  localparam logic [14:0] IOTLB_MISS = 15'd4;
  localparam logic [14:0] DDTW       = 15'd5;
  localparam logic [14:0] PDTW       = 15'd6;
  localparam logic [14:0] S1_PTW     = 15'd7;
  localparam logic [14:0] S2_PTW     = 15'd8;

  localparam int unsigned NumEv = 6;

  // Bit positions of the ev_i vector.
  typedef enum logic [2:0] {
    EvTrReq     = 3'd0,
    EvIotlbMiss = 3'd1,
    EvDdtWalk   = 3'd2,
    EvPdtWalk   = 3'd3,
    EvS1Ptw     = 3'd4,
    EvS2Ptw     = 3'd5
  } ev_idx_e;

  typedef struct packed {
    logic        of;
    logic        idt;
    logic        dv_gscv;
    logic        pv_pscv;
    logic [23:0] did_gscid;
    logic [19:0] pid_pscid;
    logic        dmask;
    logic [14:0] eventid;
  } iohpmevt_t;

  typedef struct packed {
    logic [NumEv-1:0] mask;
    logic [23:0]      did;
    logic [19:0]      pid;
    logic [19:0]      pscid;
    logic [15:0]      gscid;
    logic             pid_v;
  } evq_entry_t;

  function automatic logic [14:0] ev_eventid(input ev_idx_e idx);
    logic [14:0] id;
    id = '0;
    case (idx)
      EvTrReq:     id = UT_REQ;
      EvIotlbMiss: id = IOTLB_MISS;
      EvDdtWalk:   id = DDTW;
      EvPdtWalk:   id = PDTW;
      EvS1Ptw:     id = S1_PTW;
      EvS2Ptw:     id = S2_PTW;
      default:     id = '0;
    endcase
    return id;
  endfunction

  // With dmask the trailing ones of the reference ID are don't-care bits.
  function automatic logic id_match(input logic [23:0] a, input logic [23:0] b,
                                    input logic dmask);
    logic [23:0] cmp;
    cmp = dmask ? ~(b & ~(b + 24'd1)) : '1;
    return ((a ^ b) & cmp) == '0;
  endfunction

  function automatic logic evt_hit(input iohpmevt_t evt, input evq_entry_t ent);
    logic [NumEv-1:0] sel;
    logic             pscid_cmp, gscid_cmp;
    logic             did_ok, pid_ok, pscid_ok, gscid_ok, flt_ok;
    for (int unsigned i = 0; i < NumEv; i++) begin
      sel[i] = (evt.eventid != '0) && (evt.eventid == ev_eventid(ev_idx_e'(3'(i))));
    end
    pscid_cmp = ent.mask[EvIotlbMiss] | ent.mask[EvS1Ptw] | ent.mask[EvS2Ptw];
    gscid_cmp = pscid_cmp | ent.mask[EvPdtWalk];
    did_ok    = id_match(ent.did, evt.did_gscid, evt.dmask);
    pid_ok    = ent.pid_v && (ent.pid == evt.pid_pscid);
    pscid_ok  = !pscid_cmp || (ent.pscid == evt.pid_pscid);
    gscid_ok  = !gscid_cmp ||
                id_match({8'h00, ent.gscid}, {8'h00, evt.did_gscid[15:0]}, evt.dmask);
    case ({evt.idt, evt.dv_gscv, evt.pv_pscv})
      3'b001:  flt_ok = pid_ok;
      3'b010:  flt_ok = did_ok;
      3'b011:  flt_ok = did_ok & pid_ok;
      3'b101:  flt_ok = pscid_ok;
      3'b110:  flt_ok = gscid_ok;
      3'b111:  flt_ok = gscid_ok & pscid_ok;
      default: flt_ok = 1'b1;
    endcase
    return (|(sel & ent.mask)) & flt_ok;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with registered storage; a push is accepted while full when a pop
// happens in the same cycle.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AddrW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign cnt_d   = cnt_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iommu_hpm_evq.sv
// IOMMU hardware performance monitor front end: rising-edge event detection, an event
// queue, and per-counter event selection/filtering producing counter update strobes.
module iommu_hpm_evq
  import rv_iommu::*;
#(
  parameter int unsigned N_IOHPMCTR = 8,
  parameter int unsigned CTR_W      = 64,
  parameter int unsigned CYC_W      = 63,
  parameter int unsigned EVQ_DEPTH  = 4,
  localparam int unsigned NC        = (N_IOHPMCTR > 0) ? N_IOHPMCTR : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [5:0]                ev_i,
  input  logic [23:0]               did_i,
  input  logic [19:0]               pid_i,
  input  logic [19:0]               pscid_i,
  input  logic [15:0]               gscid_i,
  input  logic                      pid_v_i,
  input  logic                      cy_inh_i,
  input  logic [NC-1:0]             hpm_inh_i,
  input  logic [CYC_W-1:0]          cyc_q_i,
  input  logic                      cyc_of_q_i,
  output logic [CYC_W-1:0]          cyc_d_o,
  output logic                      cyc_de_o,
  output logic                      cyc_of_de_o,
  input  logic [NC-1:0][CTR_W-1:0]  ctr_q_i,
  input  iohpmevt_t [NC-1:0]        evt_i,
  output logic [NC-1:0][CTR_W-1:0]  ctr_d_o,
  output logic [NC-1:0]             ctr_de_o,
  output logic [NC-1:0]             of_de_o,
  output logic                      hpm_ip_o,
  output logic                      evq_ovf_o,
  output logic [7:0]                evq_drop_o
);

  logic [5:0]  ev_q, ev_rise;
  logic        push, pop, full, empty, drop;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;
  logic [NC-1:0] ctr_ip;
  evq_entry_t  push_data, head;

  assign ev_rise   = ev_i & ~ev_q;
  assign push      = |ev_rise;
  assign pop       = ~empty;
  assign push_data = '{mask: ev_rise, did: did_i, pid: pid_i, pscid: pscid_i,
                       gscid: gscid_i, pid_v: pid_v_i};

  fifo_v3 #(
    .DEPTH (EVQ_DEPTH),
    .dtype (evq_entry_t)
  ) u_evq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (full),
    .empty_o (empty),
    .data_i  (push_data),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign drop   = push & full & ~pop;
  assign ovf_d  = ovf_q | drop;
  assign drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ev_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ev_q   <= ev_i;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign evq_ovf_o  = ovf_q;
  assign evq_drop_o = drop_q;

  if (N_IOHPMCTR > 0) begin : g_ctr
    // The queue head is consumed in the cycle it is visible, so updates are combinational.
    always_comb begin
      ctr_d_o  = '0;
      ctr_de_o = '0;
      of_de_o  = '0;
      ctr_ip   = '0;
      for (int unsigned j = 0; j < NC; j++) begin
        ctr_d_o[j]  = ctr_q_i[j] + CTR_W'(1);
        ctr_de_o[j] = ~empty & ~hpm_inh_i[j] & evt_hit(evt_i[j], head);
        of_de_o[j]  = ctr_de_o[j] & (&ctr_q_i[j]);
        ctr_ip[j]   = of_de_o[j] & ~evt_i[j].of;
      end
    end
  end else begin : g_no_ctr
    assign ctr_d_o  = '0;
    assign ctr_de_o = '0;
    assign of_de_o  = '0;
    assign ctr_ip   = '0;
  end

  assign cyc_de_o    = ~cy_inh_i;
  assign cyc_d_o     = cyc_q_i + CYC_W'(1);
  assign cyc_of_de_o = cyc_de_o & (&cyc_q_i);
  // Only a hardware-driven 0->1 OF transition interrupts.
  assign hpm_ip_o    = (cyc_of_de_o & ~cyc_of_q_i) | (|ctr_ip);

endmodule

// File: tb/tb_iommu_hpm_evq.sv
// Self-checking bench for iommu_hpm_evq: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_iommu_hpm_evq;
  import rv_iommu::*;

  localparam int unsigned N     = 8;
  localparam int unsigned CW    = 64;
  localparam int unsigned YW    = 63;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]            ev;
  logic [23:0]           did;
  logic [19:0]           pid, pscid;
  logic [15:0]           gscid;
  logic                  pid_v, cy_inh, cyc_of_q;
  logic [N-1:0]          hpm_inh;
  logic [YW-1:0]         cyc_q, cyc_d;
  logic                  cyc_de, cyc_of_de;
  logic [N-1:0][CW-1:0]  ctr_q, ctr_d;
  iohpmevt_t [N-1:0]     evt;
  logic [N-1:0]          ctr_de, of_de;
  logic                  hpm_ip, ovf;
  logic [7:0]            drop;

  iommu_hpm_evq #(
    .N_IOHPMCTR (N),
    .CTR_W      (CW),
    .CYC_W      (YW),
    .EVQ_DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ev_i        (ev),
    .did_i       (did),
    .pid_i       (pid),
    .pscid_i     (pscid),
    .gscid_i     (gscid),
    .pid_v_i     (pid_v),
    .cy_inh_i    (cy_inh),
    .hpm_inh_i   (hpm_inh),
    .cyc_q_i     (cyc_q),
    .cyc_of_q_i  (cyc_of_q),
    .cyc_d_o     (cyc_d),
    .cyc_de_o    (cyc_de),
    .cyc_of_de_o (cyc_of_de),
    .ctr_q_i     (ctr_q),
    .evt_i       (evt),
    .ctr_d_o     (ctr_d),
    .ctr_de_o    (ctr_de),
    .of_de_o     (of_de),
    .hpm_ip_o    (hpm_ip),
    .evq_ovf_o   (ovf),
    .evq_drop_o  (drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  // Reference model: event queue as an SV queue, IDs matched bit by bit.
  typedef struct {
    logic [5:0]  mask;
    logic [23:0] did;
    logic [19:0] pid;
    logic [19:0] pscid;
    logic [15:0] gscid;
    logic        pid_v;
  } m_ent_t;

  m_ent_t      mq[$];
  logic [5:0]  m_prev = '0;
  int          m_drops = 0;
  logic        m_ovf = 1'b0;
  int unsigned ev_id_tbl [6] = '{1, 4, 5, 6, 7, 8};

  function automatic bit id_ok(logic [23:0] a, logic [23:0] b, int w, bit dm);
    int k = 0;
    if (dm) begin
      k = w;
      for (int i = 0; i < w; i++) if (!b[i]) begin k = i; break; end
    end
    for (int i = k; i < w; i++) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  function automatic bit m_hit(iohpmevt_t c, m_ent_t e);
    bit sel = 0;
    bit pscid_cmp, gscid_cmp, did_m, pid_m, pscid_m, gscid_m;
    for (int i = 0; i < 6; i++) if (e.mask[i] && c.eventid == 15'(ev_id_tbl[i])) sel = 1;
    if (!sel) return 0;
    pscid_cmp = e.mask[1] | e.mask[4] | e.mask[5];
    gscid_cmp = pscid_cmp | e.mask[3];
    did_m   = id_ok(e.did, c.did_gscid, 24, c.dmask);
    pid_m   = e.pid_v && (e.pid == c.pid_pscid);
    pscid_m = !pscid_cmp || (e.pscid == c.pid_pscid);
    gscid_m = !gscid_cmp || id_ok({8'h00, e.gscid}, c.did_gscid, 16, c.dmask);
    case ({c.idt, c.dv_gscv, c.pv_pscv})
      3'b001:  return pid_m;
      3'b010:  return did_m;
      3'b011:  return did_m && pid_m;
      3'b101:  return pscid_m;
      3'b110:  return gscid_m;
      3'b111:  return gscid_m && pscid_m;
      default: return 1;
    endcase
  endfunction

  task automatic model_advance();
    logic [5:0] rise;
    m_ent_t     ent;
    bit         popping;
    rise    = ev & ~m_prev;
    popping = (mq.size() > 0);
    if (popping) void'(mq.pop_front());
    if (rise != 0) begin
      if (mq.size() >= DEPTH && !popping) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end else begin
        ent = '{mask: rise, did: did, pid: pid, pscid: pscid, gscid: gscid, pid_v: pid_v};
        mq.push_back(ent);
      end
    end
    m_prev = ev;
  endtask

  int          obs_de [N];
  int          obs_ip, obs_both;
  logic [63:0] obs_d2;

  task automatic clr_obs();
    for (int j = 0; j < N; j++) obs_de[j] = 0;
    obs_ip = 0;
    obs_both = 0;
    obs_d2 = '1;
  endtask

  // One clock: check at negedge, advance the model, return just after the next posedge.
  task automatic step();
    logic [N-1:0]  e_de, e_of;
    logic          e_ip, e_cof;
    logic [YW-1:0] e_cyc;
    m_ent_t        h;
    @(negedge clk);
    e_de = '0;
    e_of = '0;
    if (mq.size() > 0) begin
      h = mq[0];
      for (int j = 0; j < N; j++) begin
        e_de[j] = !hpm_inh[j] && m_hit(evt[j], h);
        e_of[j] = e_de[j] && (ctr_q[j] == {CW{1'b1}});
      end
    end
    e_cof = !cy_inh && (cyc_q == {YW{1'b1}});
    e_ip  = e_cof && !cyc_of_q;
    for (int j = 0; j < N; j++) if (e_of[j] && !evt[j].of) e_ip = 1'b1;
    e_cyc = cyc_q + 1'b1;
    check_val("ctr_de", 64'(ctr_de), 64'(e_de));
    check_val("of_de", 64'(of_de), 64'(e_of));
    check_val("hpm_ip", 64'(hpm_ip), 64'(e_ip));
    check_val("cyc_de", 64'(cyc_de), 64'(!cy_inh));
    check_val("cyc_d", 64'(cyc_d), 64'(e_cyc));
    check_val("cyc_of_de", 64'(cyc_of_de), 64'(e_cof));
    check_val("evq_ovf", 64'(ovf), 64'(m_ovf));
    check_val("evq_drop", 64'(drop), 64'(m_drops));
    for (int j = 0; j < N; j++) if (e_de[j]) check_val("ctr_d", ctr_d[j], ctr_q[j] + 64'd1);
    for (int j = 0; j < N; j++) if (ctr_de[j]) obs_de[j]++;
    if (hpm_ip) obs_ip++;
    if (ctr_de[1:0] == 2'b11) obs_both++;
    if (ctr_de[2]) obs_d2 = ctr_d[2];
    if (rst_n) model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ev = '0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mq.delete();
    m_prev  = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic base_cfg();
    evt = '0;
    for (int j = 0; j < N; j++) ctr_q[j] = 64'(j * 100 + 7);
    hpm_inh = '0;
    cy_inh = 1'b1;
    cyc_q = 63'd10;
    cyc_of_q = 1'b0;
    ev = '0;
    did = '0;
    pid = '0;
    pscid = '0;
    gscid = '0;
    pid_v = 1'b0;
  endtask

  logic [14:0] eid_pool [9] = '{15'd0, 15'd1, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8, 15'd2, 15'd9};
  logic [23:0] dg_pool  [5] = '{24'h3, 24'hF, 24'h13, 24'hFFFFFF, 24'h10000F};
  logic [23:0] did_pool [4] = '{24'h3, 24'h13, 24'hF, 24'h100003};
  logic [15:0] gs_pool  [4] = '{16'h3, 16'h13, 16'hF, 16'hFFFF};
  logic [19:0] id_pool  [2] = '{20'h5, 20'hA};

  task automatic rand_cfg();
    for (int j = 0; j < N; j++) begin
      evt[j] = '0;
      evt[j].eventid   = eid_pool[$urandom_range(0, 8)];
      evt[j].idt       = 1'($urandom);
      evt[j].dv_gscv   = 1'($urandom);
      evt[j].pv_pscv   = 1'($urandom);
      evt[j].dmask     = 1'($urandom);
      evt[j].did_gscid = dg_pool[$urandom_range(0, 4)];
      evt[j].pid_pscid = id_pool[$urandom_range(0, 1)];
      evt[j].of        = 1'($urandom);
      ctr_q[j] = ($urandom_range(0, 3) == 0) ? {CW{1'b1}} : {$urandom, $urandom};
    end
    hpm_inh = N'($urandom & $urandom & $urandom);
  endtask

  task automatic rand_inputs();
    ev       = 6'($urandom & $urandom);
    did      = did_pool[$urandom_range(0, 3)];
    pid      = id_pool[$urandom_range(0, 1)];
    pscid    = id_pool[$urandom_range(0, 1)];
    gscid    = gs_pool[$urandom_range(0, 3)];
    pid_v    = 1'($urandom);
    cy_inh   = ($urandom_range(0, 3) == 0);
    cyc_of_q = 1'($urandom);
    cyc_q    = ($urandom_range(0, 15) == 0) ? {YW{1'b1}} : YW'({$urandom, $urandom});
  endtask

  initial begin
    base_cfg();
    clr_obs();
    #1;
    // Reset values, and an input held high across reset release.
    evt[0].eventid = UT_REQ;
    ev = 6'b000001;
    cy_inh = 1'b0;
    do_reset(1);
    rst_n = 1'b0;
    cy_inh = 1'b1;
    step();
    check_val("rst_ovf", 64'(ovf), 64'd0);
    check_val("rst_drop", 64'(drop), 64'd0);
    rst_n = 1'b1;
    clr_obs();
    repeat (4) step();
    check_val("held_once", 64'(obs_de[0]), 64'd1);

    // Single iotlb_miss pulse, no filter.
    base_cfg();
    evt[0].eventid = IOTLB_MISS;
    idle(2);
    clr_obs();
    ev = 6'b000010;
    step();
    idle(3);
    check_val("iotlb_pulse", 64'(obs_de[0]), 64'd1);

    // Simultaneous edges share one entry.
    evt[0].eventid = UT_REQ;
    evt[1].eventid = IOTLB_MISS;
    clr_obs();
    ev = 6'b000011;
    step();
    idle(3);
    check_val("same_cycle", 64'(obs_both), 64'd1);

    // An edge every cycle for 8 cycles.
    clr_obs();
    for (int i = 0; i < 8; i++) begin
      ev = (i % 2 == 0) ? 6'b000001 : 6'b000010;
      step();
    end
    idle(6);
    check_val("burst8", 64'(obs_de[0] + obs_de[1]), 64'd8);

    // Maximum edge rate on all bits.
    for (int i = 0; i < 16; i++) begin
      ev = (i % 2 == 0) ? 6'b010101 : 6'b101010;
      step();
    end
    idle(6);
    check_val("stress_drop", 64'(drop), 64'(m_drops));
    check_val("stress_ovf", 64'(ovf), 64'(m_ovf));

    // DID filter with dmask.
    base_cfg();
    evt[0].eventid   = IOTLB_MISS;
    evt[0].dv_gscv   = 1'b1;
    evt[0].dmask     = 1'b1;
    evt[0].did_gscid = 24'h00000F;
    idle(1);
    clr_obs();
    did = 24'h000003;
    ev = 6'b000010;
    step();
    ev = '0;
    step();
    did = 24'h000013;
    ev = 6'b000010;
    step();
    idle(3);
    check_val("did_napot", 64'(obs_de[0]), 64'd1);

    // Event counter overflow, OF clear then set.
    base_cfg();
    evt[2].eventid = UT_REQ;
    ctr_q[2] = {CW{1'b1}};
    idle(1);
    clr_obs();
    ev = 6'b000001;
    step();
    idle(3);
    check_val("of_ip", 64'(obs_ip), 64'd1);
    check_val("of_wrap_d", obs_d2, 64'd0);
    evt[2].of = 1'b1;
    clr_obs();
    ev = 6'b000001;
    step();
    idle(3);
    check_val("of_set_ip", 64'(obs_ip), 64'd0);
    check_val("of_set_de", 64'(obs_de[2]), 64'd1);

    // Cycles counter overflow.
    cy_inh = 1'b0;
    cyc_q = {YW{1'b1}};
    clr_obs();
    step();
    cyc_of_q = 1'b1;
    step();
    check_val("cyc_ip", 64'(obs_ip), 64'd1);

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) rand_cfg();
      rand_inputs();
      if (c == 300) begin
        ev = 6'b111111;
        do_reset(2);
      end
      step();
    end
    base_cfg();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
